// File: rtl/count_hold_add_n.sv
// count_hold_add_n: multi-mode arithmetic register (add, sub, accumulate,
// up/down counter with programmable terminal value, hold, load, clear).
// Every result lands in a single W+1 bit output register.
// tc is a one-cycle wrap pulse. ovf is a sticky borrow/carry flag.
module count_hold_add_n #(
    parameter int W       = 3,
    parameter int CNT_MAX = (1 << (W + 1)) - 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [2:0]   sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W:0]   dout,
    output logic         tc,
    output logic         ovf
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_HOLD = 3'b001,
        OP_UP   = 3'b010,
        OP_DOWN = 3'b011,
        OP_SUB  = 3'b100,
        OP_ACC  = 3'b101,
        OP_LOAD = 3'b110,
        OP_CLR  = 3'b111
    } op_t;

    localparam logic [W:0] CMAX = (W + 1)'(CNT_MAX);

    logic [W:0]   a_ext;
    logic [W:0]   b_ext;
    logic [W+1:0] acc_sum;
    logic [W:0]   dout_next;
    logic         tc_next;
    logic         ovf_next;
    op_t          op;

    assign a_ext   = {1'b0, a};
    assign b_ext   = {1'b0, b};
    assign acc_sum = {1'b0, dout} + {2'b00, a};
    assign op      = op_t'(sel);

    // Next-state selection: hold everything and drop tc unless en asks for an operation
    always_comb begin
        dout_next = dout;
        tc_next   = 1'b0;
        ovf_next  = ovf;
        if (en) begin
            case (op)
                OP_ADD: begin
                    dout_next = a_ext + b_ext;
                end
                OP_HOLD: begin
                    dout_next = dout;
                end
                OP_UP: begin
                    if (dout >= CMAX) begin
                        dout_next = '0;
                        tc_next   = 1'b1;
                    end else begin
                        dout_next = dout + 1'b1;
                    end
                end
                OP_DOWN: begin
                    if (dout == '0) begin
                        dout_next = CMAX;
                        tc_next   = 1'b1;
                    end else if (dout > CMAX) begin
                        dout_next = CMAX;
                    end else begin
                        dout_next = dout - 1'b1;
                    end
                end
                OP_SUB: begin
                    dout_next = a_ext - b_ext;
                    if (a < b) begin
                        ovf_next = 1'b1;
                    end
                end
                OP_ACC: begin
                    dout_next = acc_sum[W:0];
                    if (acc_sum[W+1]) begin
                        ovf_next = 1'b1;
                    end
                end
                OP_LOAD: begin
                    dout_next = a_ext;
                    ovf_next  = 1'b0;
                end
                OP_CLR: begin
                    dout_next = '0;
                    ovf_next  = 1'b0;
                end
                default: begin
                    dout_next = dout;
                end
            endcase
        end
    end

    // Output register: an active-low reset clears everything immediately, without waiting for clk
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout <= '0;
            tc   <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            dout <= dout_next;
            tc   <= tc_next;
            ovf  <= ovf_next;
        end
    end

endmodule

// File: tb/tb_count_hold_add_n.sv
// Directed-vector bench for count_hold_add_n. Uses a default instance
// (W=3, CNT_MAX=15) and a CNT_MAX=9 instance driven by the same inputs.
module tb_count_hold_add_n;

    localparam int W = 3;

    logic         clk;
    logic         rst;
    logic         en;
    logic [2:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   dout;
    logic         tc;
    logic         ovf;
    logic [W:0]   dout9;
    logic         tc9;
    logic         ovf9;

    int vectors;
    int miscompares;

    localparam logic [2:0] ADD  = 3'b000;
    localparam logic [2:0] HOLD = 3'b001;
    localparam logic [2:0] UP   = 3'b010;
    localparam logic [2:0] DOWN = 3'b011;
    localparam logic [2:0] SUB  = 3'b100;
    localparam logic [2:0] ACC  = 3'b101;
    localparam logic [2:0] LOAD = 3'b110;
    localparam logic [2:0] CLR  = 3'b111;

    count_hold_add_n #(.W(W)) dut (
        .clk(clk), .rst(rst), .en(en), .sel(sel), .a(a), .b(b),
        .dout(dout), .tc(tc), .ovf(ovf)
    );

    count_hold_add_n #(.W(W), .CNT_MAX(9)) dut9 (
        .clk(clk), .rst(rst), .en(en), .sel(sel), .a(a), .b(b),
        .dout(dout9), .tc(tc9), .ovf(ovf9)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one operation, let one rising edge take it, then settle 1 ns past the edge
    task automatic applyStimulus(input logic e, input logic [2:0] s,
                                 input logic [W-1:0] av, input logic [W-1:0] bv);
        en  = e;
        sel = s;
        a   = av;
        b   = bv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b0;
        en  = 1'b0;
        sel = HOLD;
        a   = '0;
        b   = '0;

        // Test 1: reset held over two edges, then count up 1..8
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_dout", int'(dout), 0);
        checkOutput("rst_tc", int'(tc), 0);
        checkOutput("rst_ovf", int'(ovf), 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, UP, 3'd0, 3'd0);
            checkOutput($sformatf("up_dout_%0d", i), int'(dout), i);
            checkOutput($sformatf("up_tc_%0d", i), int'(tc), 0);
        end

        // Test 2: hold twice, then add
        applyStimulus(1'b1, HOLD, 3'd0, 3'd0);
        checkOutput("hold1", int'(dout), 8);
        applyStimulus(1'b1, HOLD, 3'd0, 3'd0);
        checkOutput("hold2", int'(dout), 8);
        applyStimulus(1'b1, ADD, 3'd3, 3'd4);
        checkOutput("add_3_4", int'(dout), 7);
        applyStimulus(1'b1, ADD, 3'd1, 3'd5);
        checkOutput("add_1_5", int'(dout), 6);
        applyStimulus(1'b1, ADD, 3'd7, 3'd7);
        checkOutput("add_7_7", int'(dout), 14);
        checkOutput("add_no_ovf", int'(ovf), 0);

        // Test 3: CNT_MAX=9 instance, wrap up and down, and counting from above the terminal value
        applyStimulus(1'b1, LOAD, 3'd7, 3'd0);
        checkOutput("c9_load", int'(dout9), 7);
        applyStimulus(1'b1, UP, 3'd0, 3'd0);
        checkOutput("c9_up8", int'(dout9), 8);
        checkOutput("c9_tc8", int'(tc9), 0);
        applyStimulus(1'b1, UP, 3'd0, 3'd0);
        checkOutput("c9_up9", int'(dout9), 9);
        checkOutput("c9_tc9", int'(tc9), 0);
        applyStimulus(1'b1, UP, 3'd0, 3'd0);
        checkOutput("c9_wrap", int'(dout9), 0);
        checkOutput("c9_wrap_tc", int'(tc9), 1);
        applyStimulus(1'b1, DOWN, 3'd0, 3'd0);
        checkOutput("c9_down_wrap", int'(dout9), 9);
        checkOutput("c9_down_tc", int'(tc9), 1);
        applyStimulus(1'b1, DOWN, 3'd0, 3'd0);
        checkOutput("c9_down8", int'(dout9), 8);
        checkOutput("c9_tc_drop", int'(tc9), 0);
        applyStimulus(1'b1, ADD, 3'd7, 3'd7);
        checkOutput("c9_add14", int'(dout9), 14);
        applyStimulus(1'b1, DOWN, 3'd0, 3'd0);
        checkOutput("c9_down_above", int'(dout9), 9);
        checkOutput("c9_down_above_tc", int'(tc9), 0);
        applyStimulus(1'b1, ADD, 3'd7, 3'd5);
        applyStimulus(1'b1, UP, 3'd0, 3'd0);
        checkOutput("c9_up_above", int'(dout9), 0);
        checkOutput("c9_up_above_tc", int'(tc9), 1);

        // Test 4: subtract with borrow, sticky ovf through ADD, cleared by CLR
        applyStimulus(1'b1, SUB, 3'd2, 3'd5);
        checkOutput("sub_dout", int'(dout), 13);
        checkOutput("sub_ovf", int'(ovf), 1);
        applyStimulus(1'b1, ADD, 3'd1, 3'd1);
        checkOutput("add_after_sub", int'(dout), 2);
        checkOutput("ovf_sticky", int'(ovf), 1);
        applyStimulus(1'b1, CLR, 3'd0, 3'd0);
        checkOutput("clr_dout", int'(dout), 0);
        checkOutput("clr_ovf", int'(ovf), 0);
        applyStimulus(1'b1, SUB, 3'd5, 3'd2);
        checkOutput("sub_nob_dout", int'(dout), 3);
        checkOutput("sub_nob_ovf", int'(ovf), 0);

        // Test 5: load, accumulate through a carry, then en=0 holds
        applyStimulus(1'b1, LOAD, 3'd7, 3'd0);
        checkOutput("load7", int'(dout), 7);
        applyStimulus(1'b1, ACC, 3'd7, 3'd0);
        checkOutput("acc14", int'(dout), 14);
        checkOutput("acc14_ovf", int'(ovf), 0);
        applyStimulus(1'b1, ACC, 3'd7, 3'd0);
        checkOutput("acc5", int'(dout), 5);
        checkOutput("acc5_ovf", int'(ovf), 1);
        applyStimulus(1'b1, ACC, 3'd7, 3'd0);
        checkOutput("acc12", int'(dout), 12);
        checkOutput("acc12_ovf", int'(ovf), 1);
        applyStimulus(1'b0, UP, 3'd0, 3'd0);
        checkOutput("en0_dout", int'(dout), 12);
        checkOutput("en0_tc", int'(tc), 0);
        checkOutput("en0_ovf", int'(ovf), 1);
        applyStimulus(1'b1, UP, 3'd0, 3'd0);
        applyStimulus(1'b1, UP, 3'd0, 3'd0);
        applyStimulus(1'b1, UP, 3'd0, 3'd0);
        checkOutput("up15", int'(dout), 15);
        applyStimulus(1'b0, UP, 3'd0, 3'd0);
        checkOutput("en0_no_wrap", int'(dout), 15);
        checkOutput("en0_no_tc", int'(tc), 0);

        // Test 6: asynchronous reset mid-count, then resume from 0
        applyStimulus(1'b1, ADD, 3'd2, 3'd3);
        checkOutput("pre_rst_dout", int'(dout), 5);
        checkOutput("pre_rst_ovf", int'(ovf), 1);
        en  = 1'b1;
        sel = UP;
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_rst_dout", int'(dout), 0);
        checkOutput("async_rst_tc", int'(tc), 0);
        checkOutput("async_rst_ovf", int'(ovf), 0);
        @(posedge clk);
        #1;
        checkOutput("rst_held_dout", int'(dout), 0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b1, UP, 3'd0, 3'd0);
        checkOutput("resume_up", int'(dout), 1);
        checkOutput("resume_tc", int'(tc), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
